// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   INSTR_W_DEF     : default instruction width in bits
//   PC_W_DEF        : default program-counter / imem address width
//   PC_STEP_DEF     : default PC increment per sequential fetch
//   QUEUE_DEPTH_DEF : default instruction-queue depth (power of two, >= 2)
//   fetch_entry_t   : one queue entry, the fetched instruction and its address
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int INSTR_W_DEF     = 24;
   localparam int PC_W_DEF        = 16;
   localparam int PC_STEP_DEF     = 4;
   localparam int QUEUE_DEPTH_DEF = 4;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular instruction buffer between the fetch stage and decode.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-low reset, empties the buffer
//   flush      : empties the buffer; wins over push and pop in the same cycle
//   push       : write push_data at the tail
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored while empty)
//   head       : entry at the head, meaningful only while not_empty=1
//   not_empty  : at least one entry is held
//   count      : number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = QUEUE_DEPTH_DEF,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           head,
   output logic             not_empty,
   output logic [CNT_W-1:0] count
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // DEPTH is a power of two, so the pointers wrap at DEPTH by plain overflow.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      do_push  = push;
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head      = mem_q[rd_ptr_q];
   assign not_empty = (count_q != '0);
   assign count     = count_q;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetcher with a credit-limited request stream, a
// small instruction queue toward decode, and redirect (branch/jump) support.
// Ports:
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous active-low reset
//   redirect_valid : load redirect_pc, drop queued and in-flight instructions
//   redirect_pc    : redirect target, used unmodified
//   imem_req       : instruction-memory read strobe
//   imem_addr      : read address (the fetch PC)
//   imem_rdata     : read data, returned one cycle after an accepted request
//   out_valid      : queue head holds a valid instruction
//   out_ready      : decode accepts the head this cycle
//   out_instr      : head instruction
//   out_pc         : address of the head instruction
//   queue_count    : occupied queue entries
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              INSTR_W     = INSTR_W_DEF,
   parameter int              PC_W        = PC_W_DEF,
   parameter int              PC_STEP     = PC_STEP_DEF,
   parameter int              QUEUE_DEPTH = QUEUE_DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   localparam int             CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   queue_count
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] issued_pc_q, issued_pc_d;
   logic            inflight_q, inflight_d;
   logic            credit_ok;
   entry_t          push_entry;
   entry_t          head_entry;

   // A request is only issued when the queue can absorb its response even if
   // decode pops nothing, so a returning instruction always has a free slot.
   assign credit_ok = (int'(queue_count) + int'(inflight_q)) < QUEUE_DEPTH;
   assign imem_req  = reset && !redirect_valid && credit_ok;
   assign imem_addr = pc_q;

   always_comb begin
      pc_d        = pc_q;
      issued_pc_d = issued_pc_q;
      // A redirect forces imem_req low, which also discards the in-flight response.
      inflight_d  = imem_req;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (imem_req) begin
         pc_d        = pc_q + PC_W'(PC_STEP);
         issued_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q        <= RESET_PC;
         issued_pc_q <= '0;
         inflight_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         issued_pc_q <= issued_pc_d;
         inflight_q  <= inflight_d;
      end
   end

   assign push_entry.pc    = issued_pc_q;
   assign push_entry.instr = imem_rdata;

   fetch_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (inflight_q),
      .push_data (push_entry),
      .pop       (out_valid && out_ready),
      .head      (head_entry),
      .not_empty (out_valid),
      .count     (queue_count)
   );

   assign out_instr = head_entry.instr;
   assign out_pc    = head_entry.pc;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit with default parameters. A behavioural
// model tracks the fetch PC, the in-flight request and a scoreboard queue of
// expected PCs (pushed when a response is due, popped when decode accepts).
// The instruction memory returns addr-tagged data one cycle after a request.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [23:0] imem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_instr;
   logic [15:0] out_pc;
   logic [2:0]  queue_count;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   logic [15:0] m_pc = '0;
   logic [15:0] m_ipc = '0;
   logic        m_inflight = 1'b0;
   logic [15:0] mq[$];

   // values sampled in the most recent step, before its clock edge
   logic        s_req, s_valid;
   logic [15:0] s_addr, s_pc;
   int          n_req = 0;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .queue_count    (queue_count)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] tag(input logic [15:0] a);
      return {8'hC3, a};
   endfunction

   // Memory responds one cycle after a request; otherwise it returns junk so
   // any use of data without a request shows up.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? tag(imem_addr) : 24'hBAD000;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at negedge, compare against the model,
   // then advance the model across the rising edge.
   task automatic step(input logic rst, input logic rv, input logic [15:0] rpc, input logic rdy);
      logic m_req;
      @(negedge clk);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      m_req = rst && !rv && ((mq.size() + int'(m_inflight)) < 4);
      check("imem_req", imem_req, m_req);
      if (m_req) check("imem_addr", imem_addr, m_pc);
      check("out_valid", out_valid, mq.size() != 0);
      check("queue_count", queue_count, mq.size());
      if (mq.size() != 0) begin
         check("out_pc", out_pc, mq[0]);
         check("out_instr", out_instr, tag(mq[0]));
      end
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = out_valid;
      s_pc    = out_pc;
      if (imem_req) n_req++;
      @(posedge clk);
      if (!rst) begin
         m_pc       = 16'h0000;
         m_inflight = 1'b0;
         mq.delete();
      end else if (rv) begin
         m_pc       = rpc;
         m_inflight = 1'b0;
         mq.delete();
      end else begin
         if (rdy && mq.size() != 0) void'(mq.pop_front());
         if (m_inflight) mq.push_back(m_ipc);
         m_inflight = m_req;
         if (m_req) begin
            m_ipc = m_pc;
            m_pc  = m_pc + 16'd4;
         end
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        found, found2, seen_40;
      logic [15:0] first_pc, second_pc;

      // Reset state
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_count", queue_count, 3'd0);

      // Streaming from reset release, decode always ready
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("first_req", s_req, 1'b1);
      check("first_addr", s_addr, 16'h0000);
      check("lat_cycle1_valid", out_valid, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("lat_cycle2_valid", out_valid, 1'b1);
      check("lat_cycle2_pc", out_pc, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b0, 16'h0, 1'b1);
         check("stream_valid", s_valid, 1'b1);
         check("stream_pc", s_pc, 16'(k * 4));
      end

      // Back-pressure: exactly four requests fill the queue
      step(1'b0, 1'b0, 16'h0, 1'b0);
      n_req = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
      check("bp_req_count", n_req, 4);
      check("bp_count", queue_count, 3'd4);
      check("bp_head", out_pc, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 16'h0, 1'b1);
         check("drain_valid", s_valid, 1'b1);
         check("drain_pc", s_pc, 16'(k * 4));
      end

      // Redirect with three queued and one in flight
      step(1'b0, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
      check("pre_redir_count", queue_count, 3'd3);
      step(1'b1, 1'b1, 16'h0100, 1'b0);
      check("redir_count", queue_count, 3'd0);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("redir_req", s_req, 1'b1);
      check("redir_addr", s_addr, 16'h0100);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("redir_r2_valid", s_valid, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("redir_r3_valid", s_valid, 1'b1);
      check("redir_r3_pc", s_pc, 16'h0100);

      // Back-to-back redirects: the last one wins
      step(1'b1, 1'b1, 16'h0040, 1'b1);
      step(1'b1, 1'b1, 16'h0080, 1'b1);
      found = 1'b0;
      seen_40 = 1'b0;
      first_pc = '0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 16'h0, 1'b1);
         if (s_valid && !found) begin
            found = 1'b1;
            first_pc = s_pc;
         end
         if (s_valid && s_pc == 16'h0040) seen_40 = 1'b1;
      end
      check("b2b_found", found, 1'b1);
      check("b2b_first_pc", first_pc, 16'h0080);
      check("b2b_no_stale", seen_40, 1'b0);

      // PC wrap-around
      step(1'b1, 1'b1, 16'hFFFC, 1'b1);
      found = 1'b0;
      found2 = 1'b0;
      first_pc = '0;
      second_pc = '1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 16'h0, 1'b1);
         if (s_valid && found && !found2) begin
            found2 = 1'b1;
            second_pc = s_pc;
         end
         if (s_valid && !found) begin
            found = 1'b1;
            first_pc = s_pc;
         end
      end
      check("wrap_first", first_pc, 16'hFFFC);
      check("wrap_second", second_pc, 16'h0000);

      // Reset while full, then restart at RESET_PC
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
      check("full_count", queue_count, 3'd4);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_count", queue_count, 3'd0);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("restart_req", s_req, 1'b1);
      check("restart_addr", s_addr, 16'h0000);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

      // Reset outranks a simultaneous redirect
      step(1'b0, 1'b1, 16'h0200, 1'b1);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("rst_over_redir_addr", s_addr, 16'h0000);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fetch_unit
